// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter
//
// Purpose: shares one memory port between the instruction-fetch requester
// and the load/store requester of an RV32 core. Data requests have priority.
// A fairness counter guarantees a pending fetch is served after at most
// MAX_DATA_GRANTS consecutive data grants. Arbitration happens in IDLE and
// in the completion cycle of the current transfer, so transfers can run
// back-to-back with no idle cycle between them.
//
// Optional feature: define RV32_ARB_TIMEOUT_EN to enable the waitrequest
// timeout. After TIMEOUT_CYCLES stalled cycles the transfer is force-completed
// with readdata 0 and bus_error is pulsed. Without the macro there is no
// timeout counter and bus_error is tied low.
//
// Ports:
//   clk, reset            - single clock; asynchronous active-high reset
//   ifetch_*              - fetch requester (read only, waitrequest handshake)
//   dmem_*                - load/store requester (read/write, byteenable)
//   mem_*                 - shared memory port (registered request outputs)
//   bus_error             - one-cycle pulse on a timed-out transfer
module rv32_mem_arbiter #(
   parameter int MAX_DATA_GRANTS = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ifetch_addr,
   input  logic        ifetch_read,
   output logic [31:0] ifetch_readdata,
   output logic        ifetch_waitrequest,
   input  logic [31:0] dmem_addr,
   input  logic        dmem_read,
   input  logic        dmem_write,
   input  logic [31:0] dmem_writedata,
   input  logic [3:0]  dmem_byteenable,
   output logic [31:0] dmem_readdata,
   output logic        dmem_waitrequest,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   output logic        bus_error
);

   typedef enum logic [1:0] {IDLE, IFETCH, DATA} state_t;

   // Out-of-range parameters instantiate a module that does not exist, which
   // stops elaboration with an error instead of building a broken arbiter.
   localparam bit PARAMS_OK = (MAX_DATA_GRANTS >= 1) && (MAX_DATA_GRANTS <= 15) &&
                              (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 65535);
   generate
      if (!PARAMS_OK) begin : g_param_check
         rv32_mem_arbiter_parameter_out_of_range u_bad_param ();
      end
   endgenerate

   localparam logic [3:0] FAIR_MAX = 4'(MAX_DATA_GRANTS);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] fair_cnt;
   logic [3:0] fair_cnt_nxt;

   logic data_req;
   logic busy;
   logic timeout_hit;
   logic complete;
   logic arb;
   logic fair_full;
   logic grant_data;
   logic grant_fetch;
   logic fetch_done;
   logic data_done;

   assign data_req = dmem_read | dmem_write;
   assign busy     = (state != IDLE);

`ifdef RV32_ARB_TIMEOUT_EN
   logic [15:0] to_cnt;

   // The stalled cycle that brings the count to TIMEOUT_CYCLES is itself
   // the forced completion cycle.
   assign timeout_hit = busy && mem_waitrequest && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign bus_error   = timeout_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (grant_data || grant_fetch) begin
         to_cnt <= '0;
      end else if (busy && mem_waitrequest) begin
         to_cnt <= to_cnt + 16'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_error   = 1'b0;
`endif

   assign complete  = busy && (!mem_waitrequest || timeout_hit);
   assign arb       = !busy || complete;
   assign fair_full = (fair_cnt == FAIR_MAX);

   // Data wins unless the fetch has already waited through the full quota.
   assign grant_data  = arb && data_req && !(fair_full && ifetch_read);
   assign grant_fetch = arb && ifetch_read && !grant_data;

   assign fetch_done = complete && (state == IFETCH);
   assign data_done  = complete && (state == DATA);

   // Requester handshake is combinational so a requester sees its completion
   // in the same cycle the memory finishes. A requester that dropped its
   // request mid-transfer simply sees waitrequest low and ignores the data.
   assign ifetch_waitrequest = ifetch_read && !fetch_done;
   assign dmem_waitrequest   = data_req && !data_done;
   assign ifetch_readdata    = (fetch_done && !timeout_hit) ? mem_readdata : '0;
   assign dmem_readdata      = (data_done && !timeout_hit) ? mem_readdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         fair_cnt <= '0;
      end else begin
         state    <= state_nxt;
         fair_cnt <= fair_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fair_cnt_nxt = fair_cnt;
      if (grant_data) begin
         state_nxt = DATA;
         // Only data grants that make a waiting fetch wait longer are counted.
         if (ifetch_read && !fair_full) begin
            fair_cnt_nxt = fair_cnt + 4'd1;
         end
      end else if (grant_fetch) begin
         state_nxt    = IFETCH;
         fair_cnt_nxt = '0;
      end else if (complete) begin
         state_nxt = IDLE;
      end
   end

   // Memory request registers: loaded on grant, held while stalled, and the
   // strobes drop after completion unless a back-to-back grant reloads them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_address    <= '0;
         mem_writedata  <= '0;
         mem_byteenable <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
      end else if (grant_data) begin
         mem_address    <= dmem_addr;
         mem_writedata  <= dmem_writedata;
         mem_byteenable <= dmem_byteenable;
         // A simultaneous read and write request performs the write only.
         mem_read       <= dmem_read & ~dmem_write;
         mem_write      <= dmem_write;
      end else if (grant_fetch) begin
         mem_address    <= ifetch_addr;
         mem_writedata  <= '0;
         mem_byteenable <= 4'hF;
         mem_read       <= 1'b1;
         mem_write      <= 1'b0;
      end else if (complete) begin
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
      end
   end

endmodule
